// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the RV32 data memory controller.
//   SIZE_*      : encodings of the req_size field.
//   state_t     : controller FSM states (IDLE, SPLIT).
//   size_bytes  : number of bytes touched by an access size (0 for reserved).
package dmem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
// Write side:
//   wr_off, wr_size : byte offset within the word and access size
//   wr_phase        : 0 = low word of the access, 1 = high (next) word
//   wr_data         : right-justified store data
//   wr_be, wr_word  : byte enables and lane-shifted data for that word
// Read side:
//   rd_off, rd_size, rd_unsigned : offset, size and extension of the load
//   raw_lo, raw_hi  : raw word at the access index and the word after it
//   rd_data         : extracted and sign/zero-extended load data
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  wr_off,
  input  logic [1:0]  wr_size,
  input  logic        wr_phase,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_word,
  input  logic [1:0]  rd_off,
  input  logic [1:0]  rd_size,
  input  logic        rd_unsigned,
  input  logic [31:0] raw_lo,
  input  logic [31:0] raw_hi,
  output logic [31:0] rd_data
);

  logic [3:0]  lane_mask;
  logic [7:0]  wide_be;
  logic [63:0] wide_wdata;
  logic [31:0] rd_shift;

  // An access is treated as an 8-byte window spanning two words; the phase
  // selects which half of the window is presented to the array.
  always_comb begin
    case (wr_size)
      SIZE_B:  lane_mask = 4'b0001;
      SIZE_H:  lane_mask = 4'b0011;
      SIZE_W:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
    wide_be    = {4'b0000, lane_mask} << wr_off;
    wide_wdata = {32'h0, wr_data} << {wr_off, 3'b000};
    wr_be      = wr_phase ? wide_be[7:4] : wide_be[3:0];
    wr_word    = wr_phase ? wide_wdata[63:32] : wide_wdata[31:0];
  end

  always_comb begin
    rd_shift = 32'({raw_hi, raw_lo} >> {rd_off, 3'b000});
    case (rd_size)
      SIZE_B:  rd_data = rd_unsigned ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SIZE_H:  rd_data = rd_unsigned ? {16'h0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      SIZE_W:  rd_data = rd_shift;
      default: rd_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked word-organised data memory for the RV32 MEM stage.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_valid/ready   : request handshake; ready only in IDLE after reset
//   req_we            : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned      : load zero-extension select
//   req_addr, req_wdata : byte address, right-justified store data
//   rsp_valid         : one-cycle response pulse for the oldest request
//   rsp_rdata         : extended load data, 0 for stores and errors
//   rsp_err           : access faulted (reserved size, range, alignment)
// Accesses inside one word complete in one cycle; word-crossing accesses
// (MISALIGN_EN = 1) take a second cycle in SPLIT for the next word.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          MISALIGN_EN = 1'b1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  state_t             state_reg;
  logic               ready_reg;
  logic               rsp_valid_reg;
  logic               rsp_err_reg;
  logic               rsp_load_reg;
  // Context of the most recently accepted request; drives the high-word
  // phase in SPLIT and the read-data extraction of the response.
  logic               op_we_reg;
  logic [1:0]         op_off_reg;
  logic [1:0]         op_size_reg;
  logic               op_unsigned_reg;
  logic [31:0]        op_wdata_reg;
  logic [IDX_W-1:0]   op_idx_reg;
  logic               op_split_reg;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        rd_word_reg;
  logic [31:0]        lo_word_reg;

  logic [32:0]        diff;
  logic [2:0]         nbytes;
  logic [32:0]        end_excl;
  logic [1:0]         align_mask;
  logic               misaligned;
  logic               crosses;
  logic               req_err;
  logic               accept;
  logic               start_split;
  logic [IDX_W-1:0]   req_idx;

  logic [1:0]         wr_off;
  logic [1:0]         wr_size;
  logic               wr_phase;
  logic [31:0]        wr_data;
  logic [3:0]         wr_be;
  logic [31:0]        wr_word;
  logic [IDX_W-1:0]   mem_idx;
  logic               mem_we;
  logic [31:0]        raw_lo;
  logic [31:0]        align_rdata;

  // Request decode. The 33-bit difference exposes addresses below the base
  // in bit 32; the end-of-access check is done on the offset so it cannot
  // wrap, which also catches a crossing access whose next word is missing.
  always_comb begin
    diff       = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    nbytes     = size_bytes(req_size);
    end_excl   = {1'b0, diff[31:0]} + {30'h0, nbytes};
    align_mask = nbytes[1:0] - 2'd1;
    misaligned = |(req_addr[1:0] & align_mask);
    crosses    = ({2'b00, req_addr[1:0]} + {1'b0, nbytes}) > 4'd4;
    req_err    = (req_size == SIZE_RSV) || diff[32] || (end_excl > SPAN_BYTES)
                 || (!MISALIGN_EN && misaligned);
  end

  assign req_idx     = diff[IDX_W+1:2];
  assign req_ready   = ready_reg && (state_reg == IDLE);
  assign accept      = req_valid && req_ready;
  assign start_split = accept && !req_err && MISALIGN_EN && crosses;

  // Single array port: the incoming request in IDLE, the next word in SPLIT.
  always_comb begin
    if (state_reg == SPLIT) begin
      wr_off   = op_off_reg;
      wr_size  = op_size_reg;
      wr_phase = 1'b1;
      wr_data  = op_wdata_reg;
      mem_idx  = op_idx_reg + IDX_W'(1);
      mem_we   = op_we_reg;
    end else begin
      wr_off   = req_addr[1:0];
      wr_size  = req_size;
      wr_phase = 1'b0;
      wr_data  = req_wdata;
      mem_idx  = req_idx;
      mem_we   = accept && req_we && !req_err;
    end
  end

  assign raw_lo = op_split_reg ? lo_word_reg : rd_word_reg;

  dmem_lane_align u_align (
    .wr_off      (wr_off),
    .wr_size     (wr_size),
    .wr_phase    (wr_phase),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .wr_word     (wr_word),
    .rd_off      (op_off_reg),
    .rd_size     (op_size_reg),
    .rd_unsigned (op_unsigned_reg),
    .raw_lo      (raw_lo),
    .raw_hi      (rd_word_reg),
    .rd_data     (align_rdata)
  );

  // Array with byte-enable write and registered read. The low word of a
  // split load is parked in lo_word_reg while the high word is read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[mem_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
    rd_word_reg <= mem[mem_idx];
    if (state_reg == SPLIT) lo_word_reg <= rd_word_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ready_reg       <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_load_reg    <= 1'b0;
      op_we_reg       <= 1'b0;
      op_off_reg      <= 2'b00;
      op_size_reg     <= SIZE_B;
      op_unsigned_reg <= 1'b0;
      op_wdata_reg    <= 32'h0;
      op_idx_reg      <= '0;
      op_split_reg    <= 1'b0;
    end else begin
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_we_reg       <= req_we;
            op_off_reg      <= req_addr[1:0];
            op_size_reg     <= req_size;
            op_unsigned_reg <= req_unsigned;
            op_wdata_reg    <= req_wdata;
            op_idx_reg      <= req_idx;
            op_split_reg    <= start_split;
            rsp_load_reg    <= !req_we && !req_err;
            if (start_split) begin
              state_reg <= SPLIT;
            end else begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= req_err;
            end
          end
        end
        SPLIT: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = (rsp_valid_reg && rsp_load_reg) ? align_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SIZE_W;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ready_a, ready_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic [31:0] rdata_a, rdata_b;
  logic        err_a, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: 1 KiB at 0, split handling on. B: 64 bytes at 0x1000, misaligned = error.
  data_mem_ctrl #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .MISALIGN_EN(1'b1), .INIT_FILE("")) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_err(err_a));

  data_mem_ctrl #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .MISALIGN_EN(1'b0), .INIT_FILE("")) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .rsp_err(err_b));

  // One request on DUT `which`; returns response data, error, latency in
  // cycles (0 = no response within 4 cycles) and req_ready one cycle after accept.
  task automatic xact(input int which, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic er, output int lat, output logic rdy_mid);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (which == 0) valid_a = 1'b1; else valid_b = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0; valid_b = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0; rdy_mid = 1'b0;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) rdy_mid = (which == 0) ? ready_a : ready_b;
      if ((which == 0) ? rsp_valid_a : rsp_valid_b) begin
        lat = c;
        rd  = (which == 0) ? rdata_a : rdata_b;
        er  = (which == 0) ? err_a : err_b;
      end
    end
    $display("xact dut=%0d we=%0b size=%0d uns=%0b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
             which, we, size, uns, addr, wdata, rd, er, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid_a !== 1'b0 || rdata_a !== 32'h0 || err_a !== 1'b0 || ready_a !== 1'b0)
      begin errors++; $display("FAIL reset_hold valid=%b rdata=%08h err=%b ready=%b want 0/0/0/0", rsp_valid_a, rdata_a, err_a, ready_a); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_release_ready_early ready=%b want 0", ready_a); end
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_rise ready_a=%b ready_b=%b want 1/1", ready_a, ready_b); end
  endtask

  task automatic zero_fill();
    logic [31:0] rd; logic er; int lat; logic rm;
    for (int w = 0; w < 12; w++) xact(0, 1'b1, SIZE_W, 1'b0, 32'(w * 4), 32'h0, rd, er, lat, rm);
    xact(0, 1'b1, SIZE_W, 1'b0, 32'h3FC, 32'h0, rd, er, lat, rm);
    for (int w = 0; w < 16; w++) xact(1, 1'b1, SIZE_W, 1'b0, 32'h1000 + 32'(w * 4), 32'h0, rd, er, lat, rm);
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic er; int lat; logic rm;
    xact(0, 1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, rm);
    checks++; if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL sw_10 rdata=%08h err=%b lat=%0d want 00000000/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_B, 1'b0, 32'h13, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'hFFFFFFDE || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lb_13 rdata=%08h err=%b lat=%0d want FFFFFFDE/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_B, 1'b1, 32'h13, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h000000DE || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lbu_13 rdata=%08h err=%b lat=%0d want 000000DE/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_H, 1'b0, 32'h10, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'hFFFFBEEF || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lh_10 rdata=%08h err=%b lat=%0d want FFFFBEEF/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_H, 1'b1, 32'h12, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h0000DEAD || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lhu_12 rdata=%08h err=%b lat=%0d want 0000DEAD/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_H, 1'b0, 32'h11, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'hFFFFADBE || er !== 1'b0 || lat != 1 || rm !== 1'b1) begin errors++; $display("FAIL lh_11 rdata=%08h err=%b lat=%0d ready=%b want FFFFADBE/0/1/1", rd, er, lat, rm); end
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lw_10 rdata=%08h err=%b lat=%0d want DEADBEEF/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_RSV, 1'b0, 32'h10, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin errors++; $display("FAIL rsv_size rdata=%08h err=%b lat=%0d want 00000000/1/1", rd, er, lat); end
  endtask

  task automatic test_split();
    logic [31:0] rd; logic er; int lat; logic rm;
    xact(0, 1'b1, SIZE_W, 1'b0, 32'h22, 32'h11223344, rd, er, lat, rm);
    checks++; if (rm !== 1'b0 || er !== 1'b0 || lat != 2 || rd !== 32'h0) begin errors++; $display("FAIL sw_22_split ready=%b err=%b lat=%0d rdata=%08h want 0/0/2/00000000", rm, er, lat, rd); end
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h33440000 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lw_20 rdata=%08h err=%b lat=%0d want 33440000/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h24, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h00001122 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lw_24 rdata=%08h err=%b lat=%0d want 00001122/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h22, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h11223344 || er !== 1'b0 || lat != 2 || rm !== 1'b0) begin errors++; $display("FAIL lw_22_split rdata=%08h err=%b lat=%0d ready=%b want 11223344/0/2/0", rd, er, lat, rm); end
    xact(0, 1'b0, SIZE_H, 1'b0, 32'h23, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h00002233 || er !== 1'b0 || lat != 2) begin errors++; $display("FAIL lh_23_split rdata=%08h err=%b lat=%0d want 00002233/0/2", rd, er, lat); end
    xact(0, 1'b0, SIZE_B, 1'b1, 32'h25, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h00000011 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lbu_25 rdata=%08h err=%b lat=%0d want 00000011/0/1", rd, er, lat); end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat; logic rm;
    xact(0, 1'b1, SIZE_W, 1'b0, 32'h3FC, 32'h5A5A1234, rd, er, lat, rm);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h3FC, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h5A5A1234 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL lw_3fc rdata=%08h err=%b lat=%0d want 5A5A1234/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h400, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin errors++; $display("FAIL lw_400 rdata=%08h err=%b lat=%0d want 00000000/1/1", rd, er, lat); end
    xact(0, 1'b1, SIZE_W, 1'b0, 32'h3FE, 32'h99887766, rd, er, lat, rm);
    checks++; if (er !== 1'b1 || lat != 1 || rm !== 1'b1) begin errors++; $display("FAIL sw_3fe err=%b lat=%0d ready=%b want 1/1/1", er, lat, rm); end
    xact(0, 1'b0, SIZE_H, 1'b0, 32'h3FF, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin errors++; $display("FAIL lh_3ff rdata=%08h err=%b lat=%0d want 00000000/1/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h3FC, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h5A5A1234 || er !== 1'b0) begin errors++; $display("FAIL lw_3fc_after rdata=%08h err=%b want 5A5A1234/0", rd, er); end
  endtask

  task automatic test_no_misalign();
    logic [31:0] rd; logic er; int lat; logic rm;
    xact(1, 1'b1, SIZE_W, 1'b0, 32'h1000, 32'h12345678, rd, er, lat, rm);
    xact(1, 1'b0, SIZE_H, 1'b0, 32'h1001, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin errors++; $display("FAIL b_lh_1001 rdata=%08h err=%b lat=%0d want 00000000/1/1", rd, er, lat); end
    xact(1, 1'b1, SIZE_W, 1'b0, 32'h1002, 32'hFFFFFFFF, rd, er, lat, rm);
    checks++; if (er !== 1'b1 || lat != 1) begin errors++; $display("FAIL b_sw_1002 err=%b lat=%0d want 1/1", er, lat); end
    xact(1, 1'b0, SIZE_W, 1'b0, 32'h1000, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h12345678 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL b_lw_1000 rdata=%08h err=%b lat=%0d want 12345678/0/1", rd, er, lat); end
    xact(1, 1'b0, SIZE_H, 1'b0, 32'h1002, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h00001234 || er !== 1'b0) begin errors++; $display("FAIL b_lh_1002 rdata=%08h err=%b want 00001234/0", rd, er); end
    xact(1, 1'b0, SIZE_W, 1'b0, 32'h0FFC, 32'h0, rd, er, lat, rm);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL b_below_base err=%b rdata=%08h want 1/00000000", er, rd); end
    xact(1, 1'b0, SIZE_W, 1'b0, 32'h103C, 32'h0, rd, er, lat, rm);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL b_lw_103c err=%b rdata=%08h want 0/00000000", er, rd); end
    xact(1, 1'b0, SIZE_B, 1'b0, 32'h1040, 32'h0, rd, er, lat, rm);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL b_lb_1040 err=%b want 1", er); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_we = 1'b1; req_size = SIZE_W; req_unsigned = 1'b0; req_addr = 32'h28; req_wdata = 32'hCAFEF00D; valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_wdata = 32'h0;
    @(negedge clk);
    $display("b2b store rsp valid=%b err=%b rdata=%08h ready=%b", rsp_valid_a, err_a, rdata_a, ready_a);
    checks++;
    if (rsp_valid_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h0 || ready_a !== 1'b1)
      begin errors++; $display("FAIL b2b_store_rsp valid=%b err=%b rdata=%08h ready=%b want 1/0/00000000/1", rsp_valid_a, err_a, rdata_a, ready_a); end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    @(negedge clk);
    $display("b2b load rsp valid=%b err=%b rdata=%08h", rsp_valid_a, err_a, rdata_a);
    checks++;
    if (rsp_valid_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'hCAFEF00D)
      begin errors++; $display("FAIL b2b_load_rsp valid=%b err=%b rdata=%08h want 1/0/CAFEF00D", rsp_valid_a, err_a, rdata_a); end
    @(negedge clk);
    checks++;
    if (rsp_valid_a !== 1'b0 || rdata_a !== 32'h0) begin errors++; $display("FAIL b2b_pulse valid=%b rdata=%08h want 0/00000000", rsp_valid_a, rdata_a); end
  endtask

  task automatic test_reset_mid_split();
    logic [31:0] rd; logic er; int lat; logic rm;
    logic seen;
    @(negedge clk);
    req_we = 1'b1; req_size = SIZE_W; req_unsigned = 1'b0; req_addr = 32'h06; req_wdata = 32'hAABBCCDD; valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid_a;
    end
    $display("mid-split reset store addr=00000006 rsp_seen=%b", seen);
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_split_no_rsp rsp_valid=%b want 0", seen); end
    rst_n = 1'b1;
    @(negedge clk);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h04, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'hCCDD0000 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL mid_split_lo rdata=%08h err=%b lat=%0d want CCDD0000/0/1", rd, er, lat); end
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h08, 32'h0, rd, er, lat, rm);
    checks++; if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL mid_split_hi rdata=%08h err=%b lat=%0d want 00000000/0/1", rd, er, lat); end
  endtask

  initial begin
    test_reset();
    zero_fill();
    test_load_ext();
    test_split();
    test_range();
    test_no_misalign();
    test_back_to_back();
    test_reset_mid_split();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
